// File: rtl/mini_fetch_unit.sv
// Instruction fetch stage: program counter, loadable instruction memory and a
// valid/ready output register feeding the datapath, with branch redirect and HALT stop.
module mini_fetch_unit #(
    parameter int         PC_W        = 8,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            load_en,
    input  logic [PC_W-1:0] load_addr,
    input  logic [15:0]     load_data,
    input  logic            branch_valid,
    input  logic [5:0]      branch_offset,
    input  logic            instr_ready,
    output logic            instr_valid,
    output logic [15:0]     instruction,
    output logic [PC_W-1:0] instr_pc,
    output logic            halted,
    output logic [15:0]     fetch_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [15:0]            mem [0:(2**PC_W)-1];
    logic [PC_W-1:0]        pc;
    logic                   accept;
    logic                   fetch;
    logic                   is_halt;
    logic signed [PC_W-1:0] offset_ext;
    logic [PC_W-1:0]        tgt;
    logic [PC_W-1:0]        addr;
    logic [15:0]            word;

    assign accept     = instr_valid && instr_ready;
    assign offset_ext = {{(PC_W-6){branch_offset[5]}}, branch_offset};
    assign tgt        = instr_pc + PC_W'(1) + $unsigned(offset_ext);
    // A redirect only counts when the branching instruction is actually taken this cycle.
    assign addr       = (accept && branch_valid) ? tgt : pc;
    assign word       = mem[addr];
    assign is_halt    = (word[15:12] == HALT_OPCODE);
    assign fetch      = (state == RUN) && (!instr_valid || accept);
    assign halted     = (state == HALT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (fetch && is_halt) state_next = HALT;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Memory survives reset so a program can be replayed after restart.
    always_ff @(posedge clk) begin
        if (state == IDLE && load_en) mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            instruction <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (accept && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            if (state == IDLE && start) begin
                pc <= '0;
            end else if (fetch) begin
                if (is_halt) begin
                    instr_valid <= 1'b0;
                end else begin
                    instruction <= word;
                    instr_pc    <= addr;
                    instr_valid <= 1'b1;
                    pc          <= addr + PC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mini_fetch_unit.sv
// Bench for mini_fetch_unit: table-driven branch/wrap runs plus hand-written
// sequences, with accepted instructions checked against a scoreboard queue.
module tb_mini_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic        branch_valid;
    logic [5:0]  branch_offset;
    logic        instr_ready;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [7:0]  instr_pc;
    logic        halted;
    logic [15:0] fetch_count;

    mini_fetch_unit #(.PC_W(8), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data),
        .branch_valid(branch_valid), .branch_offset(branch_offset),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instruction(instruction), .instr_pc(instr_pc),
        .halted(halted), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ins;
    } beat_t;

    typedef struct {
        logic       has_br;
        logic [7:0] br_pc;
        logic [5:0] off;
        logic [7:0] exp_pc;
        int         n_after;
    } vec_t;

    beat_t sbq[$];
    vec_t  vecs[4];
    int    total = 0;
    int    bad   = 0;

    function automatic logic [15:0] pat(input logic [7:0] a);
        return {8'h12, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [15:0] w);
        beat_t b;
        b.pc  = p;
        b.ins = w;
        sbq.push_back(b);
    endtask

    // Every accept handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (instr_valid && instr_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_accept actual pc=%0h required none", instr_pc);
            end else begin
                beat_t e;
                e = sbq.pop_front();
                chk("beat_pc", 32'(instr_pc), 32'(e.pc));
                chk("beat_instr", 32'(instruction), 32'(e.ins));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        instr_ready  = 1'b0;
        branch_valid = 1'b0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pc(input logic [7:0] p);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(instr_valid && instr_pc == p) && n < 600);
        if (!(instr_valid && instr_pc == p)) chk("timeout_wait_pc", 32'(instr_pc), 32'(p));
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        instr_ready = 1'b0;
        chk("timeout_scoreboard", 32'(sbq.size()), 32'd0);
    endtask

    task automatic wait_halt();
        int n;
        n = 0;
        while (!halted && n < 600) begin
            tick();
            n++;
        end
        chk("timeout_halt", 32'(halted), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'd2,   6'd3,      8'd6, 3};
        vecs[1] = '{1'b1, 8'd5,   6'b111010, 8'd0, 3};
        vecs[2] = '{1'b1, 8'd254, 6'd2,      8'd1, 3};
        vecs[3] = '{1'b0, 8'd255, 6'd0,      8'd0, 2};

        start = 0; load_en = 0; load_addr = 0; load_data = 0;
        branch_valid = 0; branch_offset = 0; instr_ready = 0; reset = 0;
        tick();
        do_reset();
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_count", 32'(fetch_count), 32'd0);
        chk("reset_pc", 32'(instr_pc), 32'd0);
        chk("reset_instr", 32'(instruction), 32'd0);

        for (int i = 0; i < 256; i++) load(8'(i), pat(8'(i)));

        // Branch and wrap vectors
        for (int v = 0; v < 4; v++) begin
            logic br_done;
            int   n;
            br_done = 1'b0;
            for (int p = 0; p <= int'(vecs[v].br_pc); p++) push(8'(p), pat(8'(p)));
            for (int k = 0; k < vecs[v].n_after; k++)
                push(vecs[v].exp_pc + 8'(k), pat(vecs[v].exp_pc + 8'(k)));
            instr_ready   = 1'b1;
            branch_offset = vecs[v].off;
            start_run();
            n = 0;
            while (sbq.size() != 0 && n < 600) begin
                tick();
                n++;
                branch_valid = 1'b0;
                if (!br_done && vecs[v].has_br && instr_valid && instr_pc == vecs[v].br_pc) begin
                    branch_valid = 1'b1;
                    br_done      = 1'b1;
                end
            end
            instr_ready = 1'b0;
            chk("vec_scoreboard", 32'(sbq.size()), 32'd0);
            chk("vec_count", 32'(fetch_count),
                32'(int'(vecs[v].br_pc) + 1 + vecs[v].n_after));
            do_reset();
        end

        // Branch request while stalled is ignored
        for (int p = 0; p < 5; p++) push(8'(p), pat(8'(p)));
        instr_ready = 1'b1;
        start_run();
        wait_pc(8'd2);
        instr_ready   = 1'b0;
        branch_valid  = 1'b1;
        branch_offset = 6'd3;
        tick();
        tick();
        chk("stall_branch_pc", 32'(instr_pc), 32'd2);
        branch_valid = 1'b0;
        instr_ready  = 1'b1;
        wait_empty();
        do_reset();

        // Sequential fetch; mem[0] written in the same cycle as start
        load(8'd1, 16'h2111);
        load(8'd2, 16'h3222);
        load(8'd3, 16'hF000);
        push(8'd0, 16'h1049);
        push(8'd1, 16'h2111);
        push(8'd2, 16'h3222);
        instr_ready = 1'b1;
        load_en = 1'b1; load_addr = 8'd0; load_data = 16'h1049; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        chk("start_latency_n", 32'(instr_valid), 32'd0);
        tick();
        chk("start_latency_n1", 32'(instr_valid), 32'd1);
        wait_halt();
        tick();
        chk("seq_valid", 32'(instr_valid), 32'd0);
        chk("seq_count", 32'(fetch_count), 32'd3);
        chk("seq_hold_pc", 32'(instr_pc), 32'd2);
        chk("seq_hold_instr", 32'(instruction), 32'h3222);
        chk("seq_scoreboard", 32'(sbq.size()), 32'd0);
        do_reset();

        // Backpressure on the second instruction
        push(8'd0, 16'h1049);
        push(8'd1, 16'h2111);
        push(8'd2, 16'h3222);
        instr_ready = 1'b1;
        start_run();
        wait_pc(8'd1);
        instr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_instr", 32'(instruction), 32'h2111);
            chk("bp_pc", 32'(instr_pc), 32'd1);
        end
        instr_ready = 1'b1;
        wait_halt();
        chk("bp_count", 32'(fetch_count), 32'd3);
        chk("bp_scoreboard", 32'(sbq.size()), 32'd0);
        do_reset();

        // Reset mid-run with a write attempted during RUN
        load(8'd3, 16'h4333);
        push(8'd0, 16'h1049);
        push(8'd1, 16'h2111);
        push(8'd2, 16'h3222);
        push(8'd3, 16'h4333);
        push(8'd4, pat(8'd4));
        instr_ready = 1'b1;
        start_run();
        load_en = 1'b1; load_addr = 8'd1; load_data = 16'hABCD;
        tick();
        load_en = 1'b0;
        begin
            int n;
            n = 0;
            while (fetch_count != 16'd5 && n < 100) begin
                tick();
                n++;
            end
        end
        chk("mid_count_before", 32'(fetch_count), 32'd5);
        chk("mid_valid_before", 32'(instr_valid), 32'd1);
        do_reset();
        chk("mid_valid", 32'(instr_valid), 32'd0);
        chk("mid_count", 32'(fetch_count), 32'd0);
        chk("mid_halted", 32'(halted), 32'd0);
        chk("mid_scoreboard", 32'(sbq.size()), 32'd0);
        load(8'd3, 16'hF000);
        push(8'd0, 16'h1049);
        push(8'd1, 16'h2111);
        push(8'd2, 16'h3222);
        instr_ready = 1'b1;
        start_run();
        wait_halt();
        chk("replay_count", 32'(fetch_count), 32'd3);
        chk("replay_scoreboard", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mini_fetch_unit.md
# mini_fetch_unit

Instruction fetch stage for the MiniMIPS single-cycle datapath. Holds the program counter and a loadable 16-bit instruction memory, and presents one instruction at a time to the datapath through a valid/ready output register. It accepts branch redirects from the datapath's Branch/Branchne resolution and stops on a HALT opcode. The block sits directly upstream of the datapath's `instruction` input.

## Interface
- `PC_W`, 8: PC and instruction-memory address width. Memory depth is 2^PC_W words.
- `HALT_OPCODE`, 4'hF: value of instruction[15:12] that terminates fetch.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high. Clears all state except memory contents.
- `start`  in  1: begins execution from PC 0. Honoured only in IDLE.
- `load_en`  in  1: memory write strobe. Honoured only in IDLE.
- `load_addr`  in  PC_W: memory write address.
- `load_data`  in  16: memory write data.
- `branch_valid`  in  1: redirect request from the datapath. Qualified by an accept handshake.
- `branch_offset`  in  6: signed word offset, relative to instr_pc+1.
- `instr_ready`  in  1: datapath can accept an instruction.
- `instr_valid`  out  1: the output register holds an instruction.
- `instruction`  out  16: instruction word, stable while valid and not yet accepted.
- `instr_pc`  out  PC_W: address of the presented instruction.
- `halted`  out  1: FSM is in the HALT state.
- `fetch_count`  out  16: number of accepted instructions; saturates at 16'hFFFF.

## Operation
- **FSM states:** IDLE, RUN, HALT.
  - IDLE to RUN: when `start` is high; `pc` is set to 0.
  - RUN to HALT: on a HALT fetch (see "HALT fetch" below).
  - HALT is left only through `reset`.
- **Memory loading:**
  - Memory is written synchronously when `load_en` is high in IDLE. The write completes even if `start` is high in the same cycle.
  - `load_en` is ignored in RUN and HALT.
  - Memory is not cleared by reset.
- **Accept:** an accept occurs in any cycle where `instr_valid` and `instr_ready` are both high.
- **Fetch condition:** in RUN, a fetch occurs when the output register is empty, or when an accept happens in the same cycle.
- **Fetch address:**
  - Normally `pc`.
  - If `branch_valid` is high on an accept, the address is `tgt = instr_pc + 1 + sext(branch_offset)`, computed modulo 2^PC_W.
- **Normal fetch:**
  - The output register loads `mem[addr]`, `instr_pc` is set to `addr`, and `instr_valid` is set to 1.
  - `pc` is set to `addr + 1`, modulo 2^PC_W; PC wraps from 2^PC_W-1 to 0.
- **HALT fetch:** occurs when `mem[addr][15:12] == HALT_OPCODE`.
  - The HALT word is never presented.
  - The output register is emptied (`instr_valid` set to 0), which matters only if an accept emptied it this cycle.
  - The state moves to HALT and `pc` is frozen.
- **branch_valid without an accept:** ignored, with no effect.
- **Output register when not fetching:** holds its value while `instr_valid` is high and `instr_ready` is low.
- **fetch_count:** increments by 1 on every accept, and stops at 16'hFFFF.
- **HALT state:**
  - No fetches occur; `halted` is 1.
  - `instruction` and `instr_pc` keep their last values.
  - `instr_valid` is 0.

## Timing
- **Reset values:**
  - State is IDLE.
  - `pc`, `instruction`, `instr_pc`, `fetch_count` are 0.
  - `instr_valid` and `halted` are 0.
- **Start latency:**
  - `start` is sampled high at edge N.
  - The first fetch happens at edge N+1.
  - `instr_valid` is high after edge N+1, i.e. 2 cycles after `start` is asserted.
- **Throughput:** with `instr_ready` held at 1, one instruction is accepted per cycle, with no bubbles, including across branches.
- **Branch redirect:** takes effect at the accept edge. The next presented instruction is `mem[tgt]` one cycle later, with no wrong-path instruction.
- **Reset mid-run:** takes priority over every other input. The next cycle shows the full reset values; `instr_valid` drops immediately after the edge.
- **Simultaneous events:**
  - `start` and `load_en` in IDLE: the write happens first; the RUN fetch then sees the new word.
  - HALT fetch and accept in the same cycle: the accepted instruction is counted and the output empties.

## Test plan
- **Sequential fetch:**
  - Stimulus: load mem[0..3]=16'h1049, 16'h2111, 16'h3222, 16'hF000; pulse `start`; hold `instr_ready`=1.
  - Required response: three valid beats with `instr_pc`=0, 1, 2; then `halted`=1, `instr_valid`=0, `fetch_count`=3.
- **Backpressure:**
  - Stimulus: same program; drop `instr_ready` for 3 cycles while `instruction`=16'h2111.
  - Required response: `instruction` and `instr_pc`=1 stay stable; no skip or duplicate after release; `fetch_count` ends at 3.
- **Branch:**
  - Stimulus: forward case, accept at `instr_pc`=2 with `branch_valid`=1 and offset 6'd3. Backward case, accept at `instr_pc`=5 with offset 6'b111010 (-6).
  - Required response: forward, next `instr_pc`=6. Backward, next `instr_pc`=0.
  - Also: `branch_valid`=1 while `instr_ready`=0 has no effect.
- **PC wrap:**
  - Stimulus: mem[255]=16'h1000 and mem[0]=16'h2000 with `PC_W`=8; start execution so that PC reaches 255.
  - Required response: `instr_pc` sequence 255 then 0. A branch at 254 with offset +2 gives `instr_pc` 1.
- **Reset mid-run:**
  - Stimulus: assert `reset` for one cycle while `instr_valid`=1 and `fetch_count`=5.
  - Required response: next cycle `instr_valid`=0, `fetch_count`=0, state IDLE, `halted`=0. A fresh `start` replays from mem[0] with memory intact.
- **Load lockout:**
  - Stimulus: in RUN, `load_en`=1 with `load_addr`=1, `load_data`=16'hABCD.
  - Required response: after reset and restart, `instr_pc`=1 still shows the original word.
